player_cmd_sched: RTL and testbench

Scheduler owning the single 16-bit player instruction bus into the player datapath. Collects damage, heal and movement requests from the dodge-phase logic, buffers them and issues one command at a time over a valid/ready handshake. Fixed priority is damage > heal > move, with a minimum spacing between moves. Sits between the game-state controller and the player HP/position block.

---
 rtl/player_cmd_sched_if.sv | 26 ++
 rtl/player_cmd_sched.sv | 113 +++++++++++
 tb/tb_player_cmd_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/player_cmd_sched_if.sv
// Player instruction bus bundle: request inputs from dodge-phase logic plus the
// cmd/cmd_valid/cmd_ready handshake toward the player HP/position datapath.
// master = scheduler side, slave = the surrounding logic that drives requests and accepts commands.
interface player_cmd_sched_if;
  logic        enable;
  logic        death;
  logic        dmg_req;
  logic [7:0]  dmg_val;
  logic        heal_req;
  logic        mov_req;
  logic [1:0]  mov_dir;
  logic        cmd_ready;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        pending;

  modport master (
    input  enable, death, dmg_req, dmg_val, heal_req, mov_req, mov_dir, cmd_ready,
    output cmd, cmd_valid, pending
  );

  modport slave (
    output enable, death, dmg_req, dmg_val, heal_req, mov_req, mov_dir, cmd_ready,
    input  cmd, cmd_valid, pending
  );
endinterface

// File: rtl/player_cmd_sched.sv
// Buffers damage/heal/move requests and issues one 16-bit player command at a time, priority dmg > heal > move.
// Latency: request captured at edge 0, cmd_valid after edge 1, accepted at edge 2 with cmd_ready high.
// Backpressure: cmd is held stable while cmd_ready is low; requests keep accumulating in the buffers.
module player_cmd_sched #(
  parameter logic [7:0]  HEAL_AMT = 8'd10,
  parameter int unsigned MOV_GAP  = 4
) (
  input logic                clk,
  input logic                rst_n,
  player_cmd_sched_if.master bus
);

  localparam logic [3:0] OP_HPY     = 4'b0001;
  localparam logic [3:0] OP_DPY     = 4'b0010;
  localparam logic [3:0] OP_MOV     = 4'b0101;
  localparam logic [3:0] GAP_RELOAD = 4'(MOV_GAP - 1);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cmd, w_cmd_nxt;
  logic [7:0]  r_dmg_acc, w_dmg_nxt;
  logic [1:0]  r_heal_cnt, w_heal_nxt;
  logic        r_mov_pend, w_mov_pend_nxt;
  logic [1:0]  r_mov_dir;
  logic [3:0]  r_gap_cnt, w_gap_nxt;
  logic [8:0]  w_dmg_sum;

  logic w_capture, w_flush, w_hs, w_can_load, w_mov_accept;
  logic w_ld_dmg, w_ld_heal, w_ld_mov;

  // Requests are only taken in DODGE while alive; anything else empties the buffers.
  assign w_capture    = bus.enable & ~bus.death;
  assign w_flush      = ~w_capture;
  assign w_hs         = (r_state == ST_ISSUE) & bus.cmd_ready;
  assign w_mov_accept = w_hs & (r_cmd[15:12] == OP_MOV);
  // A new command may be loaded when the bus is free or is being freed this edge; never while flushing.
  assign w_can_load   = ((r_state == ST_IDLE) | w_hs) & ~w_flush;

  // Move spacing counter: reloads on MOV acceptance, then counts down to zero.
  always_comb begin
    w_gap_nxt = r_gap_cnt;
    if (w_mov_accept)           w_gap_nxt = GAP_RELOAD;
    else if (r_gap_cnt != 4'd0) w_gap_nxt = r_gap_cnt - 4'd1;
  end

  // Fixed-priority load select; a MOV loads on the edge where the spacing counter reaches zero,
  // so consecutive MOV acceptances land exactly MOV_GAP cycles apart under continuous ready.
  assign w_ld_dmg  = w_can_load & (r_dmg_acc != 8'd0);
  assign w_ld_heal = w_can_load & (r_dmg_acc == 8'd0) & (r_heal_cnt != 2'd0);
  assign w_ld_mov  = w_can_load & (r_dmg_acc == 8'd0) & (r_heal_cnt == 2'd0) &
                     r_mov_pend & (w_gap_nxt == 4'd0);

  // FSM next state and next command word.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    if (w_ld_dmg) begin
      w_state_nxt = ST_ISSUE;
      w_cmd_nxt   = {OP_DPY, r_dmg_acc, 4'b0000};
    end else if (w_ld_heal) begin
      w_state_nxt = ST_ISSUE;
      w_cmd_nxt   = {OP_HPY, HEAL_AMT, 4'b0000};
    end else if (w_ld_mov) begin
      w_state_nxt = ST_ISSUE;
      w_cmd_nxt   = {OP_MOV, 6'b000000, r_mov_dir, 4'b0000};
    end else if (w_hs) begin
      w_state_nxt = ST_IDLE;
      w_cmd_nxt   = 16'h0000;
    end
  end

  // Buffer updates: load clear/decrement first, then the same-edge request on top, then flush wins.
  always_comb begin
    w_dmg_sum = {1'b0, (w_ld_dmg ? 8'd0 : r_dmg_acc)} +
                ((w_capture & bus.dmg_req) ? {1'b0, bus.dmg_val} : 9'd0);
    w_dmg_nxt = w_dmg_sum[8] ? 8'hFF : w_dmg_sum[7:0];
    w_heal_nxt = r_heal_cnt - {1'b0, w_ld_heal};
    if (w_capture & bus.heal_req & (w_heal_nxt != 2'd3)) w_heal_nxt = w_heal_nxt + 2'd1;
    w_mov_pend_nxt = (r_mov_pend & ~w_ld_mov) | (w_capture & bus.mov_req);
    if (w_flush) begin
      w_dmg_nxt      = 8'd0;
      w_heal_nxt     = 2'd0;
      w_mov_pend_nxt = 1'b0;
    end
  end

  // State, command and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 16'h0000;
      r_dmg_acc  <= 8'd0;
      r_heal_cnt <= 2'd0;
      r_mov_pend <= 1'b0;
      r_mov_dir  <= 2'd0;
      r_gap_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_dmg_acc  <= w_dmg_nxt;
      r_heal_cnt <= w_heal_nxt;
      r_mov_pend <= w_mov_pend_nxt;
      r_gap_cnt  <= w_gap_nxt;
      if (w_capture & bus.mov_req) r_mov_dir <= bus.mov_dir;
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_valid = (r_state == ST_ISSUE);
  assign bus.pending   = (r_dmg_acc != 8'd0) | (r_heal_cnt != 2'd0) | r_mov_pend;

endmodule

// File: tb/tb_player_cmd_sched.sv
// Directed + randomized bench for player_cmd_sched against a transaction-level reference model.
module tb_player_cmd_sched;
  localparam logic [7:0]  HEAL_AMT = 8'd10;
  localparam int unsigned MOV_GAP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  player_cmd_sched_if bus();

  player_cmd_sched #(.HEAL_AMT(HEAL_AMT), .MOV_GAP(MOV_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers and an edge timestamp for the last MOV acceptance.
  int          m_dmg, m_heal, m_dir, cyc, last_mov;
  bit          m_mov, m_valid;
  logic [15:0] m_cmd;
  int          mov_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dmg = 0; m_heal = 0; m_dir = 0; m_mov = 0; m_valid = 0; m_cmd = 16'h0000;
    last_mov = -1000;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit hs, flush, can_load;
    logic [7:0] d8;
    hs = m_valid && bus.cmd_ready;
    if (hs && m_cmd[15:12] == 4'b0101) last_mov = cyc;
    flush    = bus.death || !bus.enable;
    can_load = (!m_valid || hs) && !flush;
    if (hs) begin m_valid = 0; m_cmd = 16'h0000; end
    if (can_load) begin
      if (m_dmg != 0) begin
        d8 = m_dmg[7:0]; m_cmd = {4'b0010, d8, 4'b0000}; m_dmg = 0; m_valid = 1;
      end else if (m_heal != 0) begin
        m_cmd = {4'b0001, HEAL_AMT, 4'b0000}; m_heal = m_heal - 1; m_valid = 1;
      end else if (m_mov && cyc >= last_mov + int'(MOV_GAP) - 1) begin
        m_cmd = {4'b0101, 6'b000000, m_dir[1:0], 4'b0000}; m_mov = 0; m_valid = 1;
      end
    end
    if (flush) begin
      m_dmg = 0; m_heal = 0; m_mov = 0;
    end else begin
      if (bus.dmg_req)  m_dmg  = (m_dmg + int'(bus.dmg_val) > 255) ? 255 : m_dmg + int'(bus.dmg_val);
      if (bus.heal_req) m_heal = (m_heal == 3) ? 3 : m_heal + 1;
      if (bus.mov_req) begin m_mov = 1; m_dir = int'(bus.mov_dir); end
    end
  endtask

  task automatic tick();
    if (bus.cmd_valid && bus.cmd_ready && bus.cmd == 16'h5010) mov_times.push_back(cyc);
    model_step();
    cyc++;
    @(posedge clk);
    #1;
    chk("cmd",       bus.cmd,       m_cmd);
    chk("cmd_valid", bus.cmd_valid, m_valid);
    chk("pending",   bus.pending,   (m_dmg != 0) || (m_heal != 0) || m_mov);
  endtask

  task automatic clr_reqs();
    bus.dmg_req = 0; bus.heal_req = 0; bus.mov_req = 0; bus.death = 0;
  endtask

  task automatic scen_single_dmg(input string tag);
    bus.cmd_ready = 1; bus.dmg_req = 1; bus.dmg_val = 8'd7;
    tick(); clr_reqs();
    chk({tag, "_pend0"},  bus.pending,   1);
    chk({tag, "_vld0"},   bus.cmd_valid, 0);
    tick();
    chk({tag, "_cmd1"},   bus.cmd,       16'h2070);
    chk({tag, "_vld1"},   bus.cmd_valid, 1);
    tick();
    chk({tag, "_vld2"},   bus.cmd_valid, 0);
    chk({tag, "_pend2"},  bus.pending,   0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    rst_n = 0;
    bus.enable = 1; bus.cmd_ready = 0; bus.dmg_val = 0; bus.mov_dir = 0;
    clr_reqs();
    #12;
    chk("rst_cmd",     bus.cmd,       16'h0000);
    chk("rst_valid",   bus.cmd_valid, 0);
    chk("rst_pending", bus.pending,   0);
    rst_n = 1;

    // Single damage request: DPY 07 two edges after the request.
    scen_single_dmg("dmg7");

    // Damage saturation while the bus is stalled behind a heal.
    bus.cmd_ready = 0; bus.heal_req = 1;
    tick(); clr_reqs();
    bus.dmg_req = 1; bus.dmg_val = 8'd200; tick();
    bus.dmg_val = 8'd100; tick(); clr_reqs();
    tick();
    chk("sat_hold_cmd", bus.cmd, 16'h10A0);
    bus.cmd_ready = 1; tick();
    chk("sat_dpy_cmd", bus.cmd, 16'h2FF0);
    tick();
    chk("sat_done_vld", bus.cmd_valid, 0);

    // Priority ordering from a single cycle of requests.
    bus.dmg_req = 1; bus.dmg_val = 8'd4; bus.heal_req = 1; bus.mov_req = 1; bus.mov_dir = 2'd3;
    tick(); clr_reqs();
    tick(); chk("prio_dpy", bus.cmd, 16'h2040);
    tick(); chk("prio_hpy", bus.cmd, 16'h10A0);
    tick(); chk("prio_mov", bus.cmd, 16'h5030);
    tick(); chk("prio_pend", bus.pending, 0);
    chk("prio_vld", bus.cmd_valid, 0);

    // Held move request: acceptances exactly MOV_GAP apart.
    mov_times.delete();
    bus.mov_req = 1; bus.mov_dir = 2'd1;
    for (int i = 0; i < 20; i++) tick();
    clr_reqs();
    for (int i = 0; i < 6; i++) tick();
    chk("mov_count", mov_times.size() >= 4, 1);
    for (int i = 1; i < mov_times.size(); i++)
      chk("mov_spacing", mov_times[i] - mov_times[i-1], 4);

    // Death while an HPY is in flight with two heals buffered.
    bus.cmd_ready = 0;
    bus.heal_req = 1; tick(); tick(); tick(); clr_reqs();
    chk("death_pre_cmd",  bus.cmd,     16'h10A0);
    chk("death_pre_pend", bus.pending, 1);
    bus.death = 1; tick(); clr_reqs();
    chk("death_hold_vld", bus.cmd_valid, 1);
    chk("death_pend",     bus.pending,   0);
    bus.cmd_ready = 1; tick();
    chk("death_acc_vld", bus.cmd_valid, 0);
    tick(); tick();
    chk("death_quiet", bus.cmd_valid, 0);

    // Asynchronous reset mid-handshake.
    bus.cmd_ready = 0; bus.dmg_req = 1; bus.dmg_val = 8'd9; bus.heal_req = 1;
    tick(); clr_reqs(); tick();
    chk("arst_pre_vld",  bus.cmd_valid, 1);
    chk("arst_pre_pend", bus.pending,   1);
    #2 rst_n = 0;
    #1;
    chk("arst_vld",  bus.cmd_valid, 0);
    chk("arst_cmd",  bus.cmd,       16'h0000);
    chk("arst_pend", bus.pending,   0);
    model_reset();
    #3 rst_n = 1;
    scen_single_dmg("post_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.enable    = ($urandom_range(0, 19) != 0);
      bus.death     = ($urandom_range(0, 39) == 0);
      bus.dmg_req   = ($urandom_range(0, 3) == 0);
      bus.dmg_val   = 8'($urandom_range(0, 255));
      bus.heal_req  = ($urandom_range(0, 3) == 0);
      bus.mov_req   = ($urandom_range(0, 2) == 0);
      bus.mov_dir   = 2'($urandom_range(0, 3));
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
